// File: rtl/btn_cmd_encoder_if.sv
// Command handshake between the button encoder (master) and the game logic (slave).
interface btn_cmd_encoder_if;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/btn_cmd_encoder.sv
// Five-button front end: synchronize, debounce, detect presses and offer one
// prioritized command at a time over a valid/ready handshake.
//
// state | meaning
// IDLE  | no command offered
// PEND  | cmd_code offered with cmd_valid high, waiting for cmd_ready
module btn_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4:0]                btn,
  btn_cmd_encoder_if.master         cmd,
  output logic [4:0]                btn_level,
  output logic [7:0]                drop_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t     state;
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] btn_sync;
  logic [CW-1:0] cnt_q [5];
  logic [4:0] level_d;
  logic [4:0] ev;
  logic [2:0] win_code;
  logic       win_dir;
  logic [2:0] dir_cnt;
  logic [2:0] lost;
  logic [2:0] inc;
  logic       any_ev;
  logic       take;
  logic [8:0] drop_sum;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      btn_level <= '0;
      level_d   <= '0;
    end else begin
      level_d <= btn_level;
      for (int i = 0; i < 5; i++) begin
        if (btn_sync[i] == btn_level[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i]     <= '0;
          btn_level[i] <= ~btn_level[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign ev     = btn_level & ~level_d;
  assign any_ev = |ev;

  always_comb begin
    win_code = 3'd0;
    win_dir  = 1'b0;
    if (ev[0]) begin
      win_code = 3'd4;
    end else if (ev[1]) begin
      win_code = 3'd0;
      win_dir  = 1'b1;
    end else if (ev[2]) begin
      win_code = 3'd1;
      win_dir  = 1'b1;
    end else if (ev[3]) begin
      win_code = 3'd2;
      win_dir  = 1'b1;
    end else if (ev[4]) begin
      win_code = 3'd3;
      win_dir  = 1'b1;
    end
  end

  // A press is loaded when nothing is pending, the pending one is being
  // accepted, or it is start; otherwise every direction press is dropped.
  assign dir_cnt  = {2'b0, ev[1]} + {2'b0, ev[2]} + {2'b0, ev[3]} + {2'b0, ev[4]};
  assign lost     = dir_cnt - {2'b0, win_dir};
  assign take     = any_ev && (state == IDLE || cmd.cmd_ready || ev[0]);
  assign inc      = take ? lost : dir_cnt;
  assign drop_sum = {1'b0, drop_cnt} + {6'b0, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_code  <= 3'd0;
      drop_cnt      <= 8'd0;
    end else begin
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state)
        IDLE: begin
          if (any_ev) begin
            state         <= PEND;
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_code  <= win_code;
          end
        end
        PEND: begin
          if (take) begin
            cmd.cmd_code <= win_code;
          end else if (cmd.cmd_ready) begin
            state         <= IDLE;
            cmd.cmd_valid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          cmd.cmd_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_btn_cmd_encoder.sv
// Directed bench for btn_cmd_encoder with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_btn_cmd_encoder;
  logic       clk;
  logic       rst_n;
  logic [4:0] btn;
  logic [4:0] btn_level;
  logic [7:0] drop_cnt;
  int         n_tests;
  int         n_fail;

  btn_cmd_encoder_if cmd_if ();

  btn_cmd_encoder #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .cmd       (cmd_if.master),
    .btn_level (btn_level),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    btn     = 5'b0;
    cmd_if.cmd_ready = 1'b0;
    tick(3);
    chk("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("rst_code",  32'(cmd_if.cmd_code), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // up held, not accepted: valid rises on the 7th edge and stays
    btn = 5'b00010;
    tick(6);
    chk("up_lat_early", 32'(cmd_if.cmd_valid), 32'd0);
    tick(1);
    chk("up_lat_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("up_code",      32'(cmd_if.cmd_code), 32'd0);
    chk("up_level",     32'(btn_level), 32'h02);
    tick(3);
    chk("up_hold", 32'(cmd_if.cmd_valid), 32'd1);

    // left while pending is dropped
    btn = 5'b01010;
    tick(10);
    chk("left_drop_code",  32'(cmd_if.cmd_code), 32'd0);
    chk("left_drop_cnt",   32'(drop_cnt), 32'd1);
    chk("left_drop_valid", 32'(cmd_if.cmd_valid), 32'd1);
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    chk("accept_valid_low", 32'(cmd_if.cmd_valid), 32'd0);
    cmd_if.cmd_ready = 1'b0;
    btn = 5'b0;
    tick(10);
    chk("release_level", 32'(btn_level), 32'd0);
    chk("release_noev",  32'(cmd_if.cmd_valid), 32'd0);

    // 3-cycle glitch on left
    btn = 5'b01000;
    tick(3);
    btn = 5'b0;
    tick(2);
    chk("glitch_level_mid", 32'(btn_level), 32'd0);
    tick(8);
    chk("glitch_level", 32'(btn_level), 32'd0);
    chk("glitch_valid", 32'(cmd_if.cmd_valid), 32'd0);

    // down pending, then start overwrites without a drop
    btn = 5'b00100;
    tick(7);
    chk("down_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("down_code",  32'(cmd_if.cmd_code), 32'd1);
    btn = 5'b00101;
    tick(7);
    chk("start_ovr_code",  32'(cmd_if.cmd_code), 32'd4);
    chk("start_ovr_drop",  32'(drop_cnt), 32'd1);
    chk("start_ovr_valid", 32'(cmd_if.cmd_valid), 32'd1);
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    chk("start_accept", 32'(cmd_if.cmd_valid), 32'd0);
    cmd_if.cmd_ready = 1'b0;
    btn = 5'b0;
    tick(10);

    // acceptance and new press on the same edge: no bubble, no drop
    btn = 5'b00010;
    tick(7);
    chk("b2b_first", 32'(cmd_if.cmd_code), 32'd0);
    btn = 5'b00110;
    tick(6);
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    chk("b2b_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("b2b_code",  32'(cmd_if.cmd_code), 32'd1);
    chk("b2b_drop",  32'(drop_cnt), 32'd1);
    tick(1);
    chk("b2b_done", 32'(cmd_if.cmd_valid), 32'd0);
    cmd_if.cmd_ready = 1'b0;
    btn = 5'b0;
    tick(10);

    // up + right together: up wins, right counted
    btn = 5'b10010;
    tick(7);
    chk("dual_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("dual_code",  32'(cmd_if.cmd_code), 32'd0);
    chk("dual_drop",  32'(drop_cnt), 32'd2);
    cmd_if.cmd_ready = 1'b1;
    btn = 5'b0;
    tick(10);
    for (int i = 0; i < 300; i++) begin
      btn = 5'b10010;
      tick(8);
      btn = 5'b0;
      tick(8);
    end
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    cmd_if.cmd_ready = 1'b0;
    tick(2);

    // async reset during PEND, then a held start re-presses after reset
    btn = 5'b00001;
    tick(7);
    chk("pend_start_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("pend_start_code",  32'(cmd_if.cmd_code), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("arst_code",  32'(cmd_if.cmd_code), 32'd0);
    chk("arst_drop",  32'(drop_cnt), 32'd0);
    chk("arst_level", 32'(btn_level), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("held_early", 32'(cmd_if.cmd_valid), 32'd0);
    tick(1);
    chk("held_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("held_code",  32'(cmd_if.cmd_code), 32'd4);
    chk("held_drop",  32'(drop_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_cmd_encoder.md
BTN_CMD_ENCODER -- requirements
Module: btn_cmd_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles (10 ms at 100 MHz) before a button level is accepted.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per raw button input (minimum 2).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btn, input, 5, raw asynchronous buttons: [0] start, [1] up, [2] down, [3] left, [4] right.
REQ-006 SHALL have port cmd_valid, output, 1, high while a command is offered.
REQ-007 SHALL have port cmd_code, output, 3, command: 0 up, 1 down, 2 left, 3 right, 4 start.
REQ-008 SHALL have port cmd_ready, input, 1, high when the game logic accepts the offered command this cycle.
REQ-009 SHALL have port btn_level, output, 5, debounced button levels.
REQ-010 SHALL have port drop_cnt, output, 8, saturating count of discarded direction presses.

Function
REQ-011 SHALL pass each btn bit through a SYNC_STAGES-flop synchronizer before any other use.
REQ-012 SHALL keep one debounce counter per button: it counts while the synchronized value differs from btn_level, clears whenever they are equal, and flips btn_level when the count reaches DEBOUNCE_CYCLES.
REQ-013 SHALL generate a press event for a button on a 0->1 transition of its btn_level bit; 1->0 transitions and held levels SHALL generate no event.
REQ-014 SHALL resolve press events in the same cycle by priority start > up > down > left > right; lower-priority simultaneous direction events SHALL be dropped and counted.
REQ-015 SHALL implement FSM states IDLE and PEND; reset state is IDLE.
REQ-016 In IDLE, a press event SHALL load cmd_code and move to PEND, with cmd_valid high from the next cycle.
REQ-017 In PEND, cmd_valid SHALL stay high and cmd_code SHALL stay stable until a cycle with cmd_ready=1, after which the FSM returns to IDLE with cmd_valid low from the next cycle.
REQ-018 In PEND, a direction press event without acceptance SHALL be discarded and drop_cnt SHALL be incremented.
REQ-019 In PEND, a start press event SHALL overwrite cmd_code with 4 and remain in PEND; a displaced direction command is not counted as a drop.
REQ-020 If acceptance and a new press event occur in the same cycle, the new event SHALL be loaded and the FSM SHALL stay in PEND, with no bubble and no drop.
REQ-021 drop_cnt SHALL saturate at 255 and clear only on reset.
REQ-022 Press-to-valid latency SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk cycles from the first clk edge sampling the new raw level.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no event and leave btn_level unchanged.

Reset
REQ-024 While rst_n=0, the block SHALL hold cmd_valid=0, cmd_code=0, btn_level=0, drop_cnt=0, all synchronizer flops and counters at 0, and the FSM in IDLE, independent of clk.
REQ-025 Reset asserted mid-operation (debounce in progress or PEND) SHALL discard the pending command and partial counts.
REQ-026 After rst_n deasserts, a button already held SHALL produce one press event after the REQ-022 latency.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-027 Hold btn=5'b00010 with cmd_ready=0 -> cmd_valid rises exactly 7 cycles later with cmd_code=0, and stays high.
REQ-028 Pulse btn[3] high for 3 cycles -> no cmd_valid, btn_level[3] stays 0.
REQ-029 Press up, then press left while pending with cmd_ready=0 -> cmd_code stays 0 and drop_cnt=1; assert cmd_ready -> cmd_valid low next cycle.
REQ-030 Press down while pending, then press start -> cmd_code changes to 4 and drop_cnt is unchanged.
REQ-031 Press up and right in the same cycle -> cmd_code=0 and drop_cnt=1; 300 such drops -> drop_cnt=255.
REQ-032 Assert rst_n=0 asynchronously during PEND -> cmd_valid=0 immediately, all outputs return to 0.
